// File: rtl/sha_block_sequencer.sv
// Sequences a SHA-256 compression core over CNT_N software-loaded 512-bit blocks.
// Latency: register reads 1 cycle; core_init/core_next issue 1 cycle after core_ready is seen in KICK.
// Backpressure: KICK holds until core_ready; LOAD holds until software writes NEXT; WAIT bounded by TIMEOUT.
//
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   address/chipselect/write_n/
//   writedata/readdata                Avalon-MM slave (CTRL, CNT_N, STATUS, CYCLES)
//   irq                               level interrupt, done_flag & irq_en
//   core_ready/core_done              hash core status inputs
//   core_init/core_next               one-cycle core kick pulses
//   busy                              high while the FSM is not IDLE
module sha_block_sequencer #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        core_ready,
    input  logic        core_done,
    output logic        core_init,
    output logic        core_next,
    output logic        busy
);

    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_CNT    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CYCLES = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        KICK = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t             state_q;
    logic [31:0]        readdata_q;
    logic               core_init_q;
    logic               core_next_q;
    logic [CNT_W-1:0]   cnt_n_q;
    logic [CNT_W-1:0]   remaining_q;
    logic               done_flag_q;
    logic               err_flag_q;
    logic               irq_en_q;
    logic               need_block_q;
    logic               first_q;
    logic [31:0]        cycles_q;
    logic [TMO_W-1:0]   tmo_q;

    // Bus decode
    logic wr_en;
    logic ctrl_wr;
    logic cnt_wr;
    logic stat_wr;
    logic cmd_abort;
    logic cmd_start;
    logic cmd_next;

    assign wr_en     = chipselect & ~write_n;
    assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
    assign cnt_wr    = wr_en && (address == ADDR_CNT);
    assign stat_wr   = wr_en && (address == ADDR_STATUS);
    // ABORT masks START/NEXT carried in the same CTRL write.
    assign cmd_abort = ctrl_wr & writedata[2];
    assign cmd_start = ctrl_wr & writedata[0] & ~writedata[2];
    assign cmd_next  = ctrl_wr & writedata[1] & ~writedata[2];

    // Upper writedata bits have no destination.
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:CNT_W];

    logic [31:0] status_w;
    logic [31:0] rd_mux;

    always_comb begin
        status_w             = '0;
        status_w[0]          = busy;
        status_w[1]          = need_block_q;
        status_w[2]          = done_flag_q;
        status_w[3]          = err_flag_q;
        status_w[8 +: CNT_W] = remaining_q;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_CTRL:   rd_mux = '0;
            ADDR_CNT:    rd_mux = 32'(cnt_n_q);
            ADDR_STATUS: rd_mux = status_w;
            ADDR_CYCLES: rd_mux = cycles_q;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            readdata_q   <= '0;
            core_init_q  <= 1'b0;
            core_next_q  <= 1'b0;
            cnt_n_q      <= '0;
            remaining_q  <= '0;
            done_flag_q  <= 1'b0;
            err_flag_q   <= 1'b0;
            irq_en_q     <= 1'b0;
            need_block_q <= 1'b0;
            first_q      <= 1'b0;
            cycles_q     <= '0;
            tmo_q        <= '0;
        end else begin
            core_init_q <= 1'b0;
            core_next_q <= 1'b0;
            readdata_q  <= rd_mux;

            if (ctrl_wr) begin
                irq_en_q <= writedata[3];
            end
            if (cnt_wr && (state_q == IDLE)) begin
                cnt_n_q <= writedata[CNT_W-1:0];
            end
            // Flag sets later in this block override this clear.
            if (stat_wr) begin
                done_flag_q <= 1'b0;
                err_flag_q  <= 1'b0;
            end
            if ((state_q != IDLE) && (cycles_q != 32'hFFFF_FFFF)) begin
                cycles_q <= cycles_q + 32'd1;
            end

            if (cmd_abort && (state_q != IDLE)) begin
                state_q      <= IDLE;
                need_block_q <= 1'b0;
                remaining_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd_start) begin
                            if (cnt_n_q == '0) begin
                                err_flag_q <= 1'b1;
                            end else begin
                                remaining_q  <= cnt_n_q;
                                first_q      <= 1'b1;
                                cycles_q     <= '0;
                                done_flag_q  <= 1'b0;
                                err_flag_q   <= 1'b0;
                                need_block_q <= 1'b1;
                                state_q      <= LOAD;
                            end
                        end
                    end
                    LOAD: begin
                        if (cmd_next) begin
                            need_block_q <= 1'b0;
                            state_q      <= KICK;
                        end
                    end
                    KICK: begin
                        if (core_ready) begin
                            if (first_q) begin
                                core_init_q <= 1'b1;
                            end else begin
                                core_next_q <= 1'b1;
                            end
                            first_q <= 1'b0;
                            tmo_q   <= '0;
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        tmo_q <= tmo_q + 1'b1;
                        // core_done takes precedence over a coincident timeout.
                        if (core_done) begin
                            if (remaining_q != '0) begin
                                remaining_q <= remaining_q - 1'b1;
                            end
                            if (remaining_q <= CNT_W'(1)) begin
                                done_flag_q <= 1'b1;
                                state_q     <= IDLE;
                            end else begin
                                need_block_q <= 1'b1;
                                state_q      <= LOAD;
                            end
                        end else if (tmo_q == TMO_LAST) begin
                            err_flag_q <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign readdata  = readdata_q;
    assign core_init = core_init_q;
    assign core_next = core_next_q;
    assign busy      = (state_q != IDLE);
    assign irq       = done_flag_q & irq_en_q;

endmodule

// File: tb/tb_sha_block_sequencer.sv
module tb_sha_block_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        core_ready;
    logic        core_done;
    logic        core_init;
    logic        core_next;
    logic        busy;

    sha_block_sequencer #(.CNT_W(8), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .core_ready (core_ready),
        .core_done  (core_done),
        .core_init  (core_init),
        .core_next  (core_next),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Pulse / busy monitor, sampled on the falling edge.
    int   init_cnt  = 0;
    int   next_cnt  = 0;
    int   viol_cnt  = 0;
    int   busy_cnt  = 0;
    logic prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (core_init) init_cnt++;
        if (core_next) next_cnt++;
        if (core_init && core_next) viol_cnt++;
        if ((core_init || core_next) && prev_pulse) viol_cnt++;
        prev_pulse = core_init | core_next;
        if (busy) busy_cnt++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    typedef struct {
        logic        is_wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[15];

    int i0;
    int n0;
    int n;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        core_ready = 1'b1;
        core_done  = 1'b0;

        vecs[0]  = '{1'b0, 2'd2, 32'h0,         32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 2'd3, 32'h0,         32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 2'd1, 32'h0,         32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b1, 2'd1, 32'h0000_005A, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, 2'd1, 32'h0,         32'h0000_005A, 1'b0};
        vecs[6]  = '{1'b1, 2'd1, 32'hFFFF_FF3C, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 2'd1, 32'h0,         32'h0000_003C, 1'b0};
        vecs[8]  = '{1'b1, 2'd1, 32'h0,         32'h0,         1'b0};
        vecs[9]  = '{1'b1, 2'd0, 32'h0000_0001, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 2'd2, 32'h0,         32'h0000_0008, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 32'h0,         32'h0000_0000, 1'b0};
        vecs[12] = '{1'b1, 2'd2, 32'h0,         32'h0,         1'b0};
        vecs[13] = '{1'b0, 2'd2, 32'h0,         32'h0000_0000, 1'b0};
        vecs[14] = '{1'b0, 2'd3, 32'h0,         32'h0000_0000, 1'b0};

        repeat (3) tick();
        reset_n = 1'b1;

        // Reset state
        check("rst_readdata",  readdata,  32'h0);
        check("rst_irq",       32'(irq),       32'h0);
        check("rst_core_init", 32'(core_init), 32'h0);
        check("rst_core_next", 32'(core_next), 32'h0);
        check("rst_busy",      32'(busy),      32'h0);

        // Register access table, including START with CNT_N=0 and STATUS clear
        i0 = init_cnt;
        n0 = next_cnt;
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].is_wr) begin
                bus_wr(vecs[i].addr, vecs[i].data);
            end else begin
                address = vecs[i].addr;
                tick();
                check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
        end
        check("cnt0_no_pulse", 32'((init_cnt - i0) + (next_cnt - n0)), 32'h0);

        // Two-block run with IRQ_EN
        bus_wr(2'd1, 32'd2);
        busy_cnt = 0;
        i0 = init_cnt;
        n0 = next_cnt;
        bus_wr(2'd0, 32'h9);
        check("run2_busy", 32'(busy), 32'h1);
        address = 2'd2;
        tick();
        check("run2_st_load1", readdata, 32'h0000_0203);
        bus_wr(2'd0, 32'hA);
        address = 2'd2;
        repeat (5) tick();
        check("run2_st_wait1", readdata, 32'h0000_0201);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        check("run2_st_load2", readdata, 32'h0000_0103);
        bus_wr(2'd0, 32'hA);
        address = 2'd2;
        tick();
        check("run2_st_kick2", readdata, 32'h0000_0101);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("run2_busy_end", 32'(busy), 32'h0);
        check("run2_irq",      32'(irq),  32'h1);
        tick();
        check("run2_st_done", readdata, 32'h0000_0004);
        check("run2_init_pulses", 32'(init_cnt - i0), 32'd1);
        check("run2_next_pulses", 32'(next_cnt - n0), 32'd1);
        address = 2'd3;
        tick();
        check("run2_cycles",      readdata, 32'd12);
        check("run2_cycles_busy", readdata, 32'(busy_cnt));
        bus_wr(2'd2, 32'h0);
        check("run2_irq_clr", 32'(irq), 32'h0);
        address = 2'd2;
        tick();
        check("run2_st_clr", readdata, 32'h0);

        // KICK stall on core_ready, then timeout with no core_done
        bus_wr(2'd1, 32'd1);
        core_ready = 1'b0;
        bus_wr(2'd0, 32'h1);
        bus_wr(2'd0, 32'h2);
        i0 = init_cnt;
        n0 = next_cnt;
        repeat (4) tick();
        check("kick_stall_busy",  32'(busy), 32'h1);
        check("kick_stall_noinit", 32'(init_cnt - i0), 32'd0);
        core_ready = 1'b1;
        check("kick_init_pre", 32'(core_init), 32'h0);
        tick();
        check("kick_init_now", 32'(core_init), 32'h1);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("tmo_cycles", 32'(n), 32'd16);
        check("tmo_pulses", 32'((init_cnt - i0) + (next_cnt - n0)), 32'd1);
        address = 2'd2;
        tick();
        check("tmo_status", readdata, 32'h0000_0108);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        check("idle_done_ignored", readdata, 32'h0000_0108);
        check("idle_done_busy", 32'(busy), 32'h0);

        // ABORT together with NEXT in LOAD, then a normal single-block run
        bus_wr(2'd2, 32'h0);
        bus_wr(2'd1, 32'd2);
        bus_wr(2'd0, 32'h1);
        bus_wr(2'd1, 32'd7);
        i0 = init_cnt;
        n0 = next_cnt;
        bus_wr(2'd0, 32'h6);
        check("abort_busy", 32'(busy), 32'h0);
        repeat (3) tick();
        check("abort_no_pulse", 32'((init_cnt - i0) + (next_cnt - n0)), 32'd0);
        address = 2'd2;
        tick();
        check("abort_status", readdata, 32'h0);
        address = 2'd1;
        tick();
        check("cnt_wr_busy_ignored", readdata, 32'd2);
        bus_wr(2'd1, 32'd1);
        bus_wr(2'd0, 32'h1);
        bus_wr(2'd0, 32'h2);
        tick();
        check("run1_init", 32'(core_init), 32'h1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("run1_busy", 32'(busy), 32'h0);
        address = 2'd2;
        tick();
        check("run1_status", readdata, 32'h0000_0004);

        // Reset mid-WAIT with remaining=3
        bus_wr(2'd2, 32'h0);
        bus_wr(2'd1, 32'd3);
        bus_wr(2'd0, 32'h1);
        bus_wr(2'd0, 32'h2);
        tick();
        check("rstw_busy_pre", 32'(busy), 32'h1);
        address = 2'd2;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rstw_readdata",  readdata,        32'h0);
        check("rstw_irq",       32'(irq),       32'h0);
        check("rstw_core_init", 32'(core_init), 32'h0);
        check("rstw_core_next", 32'(core_next), 32'h0);
        check("rstw_busy",      32'(busy),      32'h0);
        tick();
        check("rstw_status", readdata, 32'h0);
        i0 = init_cnt;
        n0 = next_cnt;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        check("rstw_done_ignored", readdata, 32'h0);
        check("rstw_busy_after",   32'(busy), 32'h0);
        check("rstw_no_pulse", 32'((init_cnt - i0) + (next_cnt - n0)), 32'd0);
        address = 2'd1;
        tick();
        check("rstw_cnt", readdata, 32'h0);

        check("pulse_rules", 32'(viol_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sha_block_sequencer.md
Name: sha_block_sequencer

Overview:
- Avalon-MM slave controller that sequences a SHA-256 compression core over a software-programmed number of 512-bit blocks (CNT_N).
- The HPS loads each block through the existing word PIOs. This block runs the handshake: start, request the next block, kick the core, wait for completion, count down, and flag done, error or abort.
- Sits between the HPS lightweight bridge and the hash core. It replaces software polling of individual PIOs with one register-mapped state machine.

Parameters:
- CNT_W, 8, width of block count and blocks-remaining fields.
- TIMEOUT, 1024, max cycles in WAIT before an error is declared; must be >= 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  level interrupt = done_flag & irq_en
- core_ready  in  1  core idle and able to accept init/next
- core_done  in  1  one-cycle pulse when a block compression finishes
- core_init  out  1  one-cycle pulse: first block, core reloads IV
- core_next  out  1  one-cycle pulse: subsequent block, chained digest
- busy  out  1  high whenever state != IDLE

Behaviour:
- All state updates on rising clk. Reset takes priority over every other event.
- Reset values:
  - state=IDLE
  - readdata=0, irq=0, core_init=0, core_next=0, busy=0
  - cnt_n=0, remaining=0, done_flag=0, err_flag=0, irq_en=0, need_block=0, cycles=0, tmo=0
- Write = chipselect & ~write_n.
- Register map:
  - addr 0 CTRL (write only, reads 0).
    - bit0 START, bit1 NEXT, bit2 ABORT, bit3 IRQ_EN (stored).
    - Bits 0-2 are self-clearing strobes.
  - addr 1 CNT_N (R/W), bits[CNT_W-1:0].
    - Write is ignored while busy.
  - addr 2 STATUS (R). Write clears done_flag and err_flag (write-any-value-clears).
    - bit0 busy, bit1 need_block, bit2 done_flag, bit3 err_flag.
    - bits[8+CNT_W-1:8] remaining. Other bits 0.
  - addr 3 CYCLES (R).
    - 32-bit count of cycles spent non-IDLE in the current/last run.
    - Cleared on START accept. Saturates at 0xFFFFFFFF.
- readdata is updated every cycle, regardless of chipselect, with the mux of address. Read latency is 1 cycle.
- FSM states: IDLE, LOAD, KICK, WAIT.
  - IDLE:
    - START with cnt_n==0: set err_flag, stay IDLE.
    - START with cnt_n!=0: remaining<=cnt_n, first<=1, cycles<=0, done_flag<=0, err_flag<=0, go to LOAD.
  - LOAD:
    - need_block=1.
    - NEXT: go to KICK, need_block<=0.
  - KICK:
    - Waits for core_ready=1.
    - Then pulses core_init if first, else core_next, for exactly one cycle.
    - Clears first, tmo<=0, goes to WAIT.
  - WAIT:
    - tmo increments each cycle.
    - core_done: remaining<=remaining-1.
      - If remaining==1: done_flag<=1, go to IDLE.
      - Else go to LOAD.
    - tmo==TIMEOUT-1 without core_done: err_flag<=1, go to IDLE.
- ABORT in any non-IDLE state: go to IDLE, need_block<=0, remaining<=0. No flag is set and no core pulse is issued.
- ABORT wins over START or NEXT written in the same cycle.
- Ignored events:
  - START while busy.
  - NEXT outside LOAD.
  - core_done outside WAIT.
- core_done and timeout in the same cycle: core_done wins.
- STATUS-clear write in the same cycle as a flag set: the set wins.
- core_init and core_next are never high together and never high for two consecutive cycles.
- remaining never wraps below 0.

Test Plan:
- Reset mid-WAIT with remaining=3 -> next cycle every output is 0 and STATUS reads 0; a later core_done pulse is ignored.
- CNT_N=2, START, NEXT, core_done after 5 cycles, NEXT, core_done -> sequence:
  - core_init then core_next, one pulse each.
  - STATUS passes through 0x0203, 0x0101, then 0x0004.
  - irq=1 if IRQ_EN set.
  - CYCLES matches the number of busy cycles.
- CNT_N=0, START -> STATUS=0x0008 and no core pulse. Writing STATUS clears it to 0.
- KICK with core_ready=0 for 4 cycles -> core_init is asserted only in the cycle after core_ready rises.
- TIMEOUT=16, core_done never arrives -> err_flag set exactly 16 cycles after the core_init pulse; busy=0.
- ABORT written together with NEXT in LOAD -> IDLE, no core pulse, STATUS=0. A subsequent START with CNT_N=1 runs normally.
